motor_bridge_ctrl: RTL
======================

// Module: motor_bridge_ctrl
// PURPOSE
//  Parametrised N-channel H-bridge controller, successor to the combinational per-motor decode.
//  Generates PWM internally from per-channel duty words, with glitch-free duty updates at period
//  boundaries. Inserts programmable dead time on every bridge state change and flags when a
//  coasting channel has settled for back-EMF sampling. Sits between the bus register block and
//  the motor driver pins (MotorA/MotorB/MotorC per channel).
// PARAMETERS
//  NUM_MOTORS    4   number of bridge channels
//  PWM_W         8   PWM counter/duty width; period = 2**PWM_W clocks
//  DEAD_W        4   width of DeadTime input (max dead time 2**DEAD_W-1 clocks)
//  BLANK_CYCLES  16  consecutive measure-coast clocks before MeasureReady asserts (>=1)
// PORTS
//  Clk           in   1               system clock; all logic rising-edge
//  ResetN        in   1               asynchronous, active-low reset
//  Enable        in   1               global enable; 0 forces every channel's target to COAST
//  Control       in   2*NUM_MOTORS    per channel [2i+1:2i]: 00 coast, 01 fwd, 10 rev, 11 brake
//  Duty          in   PWM_W*NUM_MOTORS per channel duty word, shadowed per period
//  Measure       in   NUM_MOTORS      per channel back-EMF measure request
//  DeadTime      in   DEAD_W          dead-time length in clocks, shared; 0 = none
//  MotorA        out  NUM_MOTORS      forward drive
//  MotorB        out  NUM_MOTORS      reverse drive
//  MotorC        out  NUM_MOTORS      coast / fast-decay select
//  MeasureReady  out  NUM_MOTORS      channel coasted >= BLANK_CYCLES with Measure high
//  PwmSync       out  1               one-clock pulse at start of each PWM period
// BEHAVIOUR
//  Reset (ResetN=0, async): Cnt=0, all duty shadows=0, every FSM in COAST (A=0,B=0,C=1).
//   Also MeasureReady=0, PwmSync=0, dead/blank counters=0.
//  PWM: PWM_W-bit Cnt increments every clock and wraps 2**PWM_W-1 -> 0.
//   PwmSync is registered: high for the one clock after Cnt==0.
//   Duty shadows load from Duty when Cnt==2**PWM_W-1; they are used from Cnt==0.
//   PwmOn[i] = Cnt < Shadow[i]. Duty 0 never drives; max duty drives 2**PWM_W-1 of 2**PWM_W clocks.
//  Target per channel, combinational, priority order:
//   Measure | ~Enable | Control==00 -> COAST
//   else ~PwmOn | Control==11       -> BRAKE
//   else Control==01 -> FWD, Control==10 -> REV
//  FSM per channel: COAST(0,0,1) BRAKE(0,0,0) FWD(1,0,0) REV(0,1,0) DEAD(0,0,0); outputs (A,B,C).
//   Outputs are registered decodes of the state: one clock from target change to pin change.
//   Steady state S with target==S: hold.
//   Target!=S and DeadTime==0: go directly to the target.
//   Target!=S and DeadTime>0: enter DEAD, load counter with DeadTime.
//   DEAD: hold exactly DeadTime clocks, then go to the target current at exit (may equal old S).
//   DeadTime changes during DEAD take effect at the next DEAD entry.
//  Invariants: A&B never 1 together. FWD<->REV never adjacent when DeadTime>0.
//   C=1 only in COAST.
//  MeasureReady[i]: saturating blank counter increments while state==COAST and Measure[i]=1.
//   Counter clears otherwise. MeasureReady=1 once count >= BLANK_CYCLES.
//   Dropping Measure or leaving COAST clears MeasureReady on the next clock.
//  Channels are fully independent; only Cnt, PwmSync and DeadTime are shared.
//  ResetN asserted mid-dead-time or mid-period: immediate COAST on all pins, counters restart.
// TESTING
//  1 ResetN=0 during FWD drive -> same-instant A=B=0,C=1 all chans; MeasureReady=0; PwmSync=0.
//  2 PWM_W=8, DeadTime=0, Control=01, Duty=64:
//    A high 64 clocks per 256, A rises 1 clock after Cnt==0; PwmSync period 256.
//  3 DeadTime=3, Duty=200, Control 01->10 mid-on-time:
//    A falls, exactly 3 clocks (0,0,0), then B rises; assert ~(A&B) throughout.
//  4 Duty 64->192 written at Cnt=100 -> current period still 64 on-clocks; next period 192.
//  5 BLANK_CYCLES=16, DeadTime=2, Measure=1 while FWD:
//    DEAD 2 clocks -> COAST; MeasureReady rises 16 clocks after COAST entry.
//    Measure=0 -> MeasureReady=0 next clock, drive resumes after 2-clock DEAD.
//  6 Control=11 -> constant (0,0,0), no DEAD toggling. Enable=0 with Control=01 -> COAST.
//    Duty=0 with Control=01 -> BRAKE steady.

Source files
------------

// File: rtl/motor_bridge_ctrl_if.sv
// Purpose : bundle of register-side controls and driver-pin outputs for motor_bridge_ctrl.
// Latency : n/a (signal bundle only).
// Backpr. : none; level signals, no handshake.
// Ports   : master = register block (drives Enable/Control/Duty/Measure/DeadTime,
//           observes pins); slave = bridge controller (the reverse directions).
interface motor_bridge_ctrl_if #(
   parameter int NUM_MOTORS = 4,
   parameter int PWM_W      = 8,
   parameter int DEAD_W     = 4
);
   logic                        Enable;
   logic [2*NUM_MOTORS-1:0]     Control;
   logic [PWM_W*NUM_MOTORS-1:0] Duty;
   logic [NUM_MOTORS-1:0]       Measure;
   logic [DEAD_W-1:0]           DeadTime;
   logic [NUM_MOTORS-1:0]       MotorA;
   logic [NUM_MOTORS-1:0]       MotorB;
   logic [NUM_MOTORS-1:0]       MotorC;
   logic [NUM_MOTORS-1:0]       MeasureReady;
   logic                        PwmSync;

   modport master (
      output Enable, Control, Duty, Measure, DeadTime,
      input  MotorA, MotorB, MotorC, MeasureReady, PwmSync
   );

   modport slave (
      input  Enable, Control, Duty, Measure, DeadTime,
      output MotorA, MotorB, MotorC, MeasureReady, PwmSync
   );
endinterface

// File: rtl/motor_bridge_ctrl.sv
// Purpose : N-channel H-bridge controller: internal PWM with per-period duty shadows,
//           dead-time insertion on every bridge state change, back-EMF settle flag.
// Latency : one clock from target change to pin change (pins are registered).
// Backpr. : none; level-driven, pins always reflect current FSM state.
// Ports   : Clk, ResetN (async active-low); bus.slave carries Enable/Control/Duty/
//           Measure/DeadTime in and MotorA/B/C, MeasureReady, PwmSync out.
module motor_bridge_ctrl #(
   parameter int NUM_MOTORS   = 4,
   parameter int PWM_W        = 8,
   parameter int DEAD_W       = 4,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                Clk,
   input  logic                ResetN,
   motor_bridge_ctrl_if.slave  bus
);
   localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
   localparam logic [BLANK_W-1:0] BLANK_MAX = BLANK_W'(BLANK_CYCLES);

   typedef enum logic [2:0] {ST_COAST, ST_BRAKE, ST_FWD, ST_REV, ST_DEAD} state_t;

   logic [PWM_W-1:0]   cnt_q, cnt_d;
   logic               sync_q, sync_d;
   logic [PWM_W-1:0]   shadow_q [NUM_MOTORS];
   logic [PWM_W-1:0]   shadow_d [NUM_MOTORS];
   state_t             state_q  [NUM_MOTORS];
   state_t             state_d  [NUM_MOTORS];
   logic [DEAD_W-1:0]  dead_q   [NUM_MOTORS];
   logic [DEAD_W-1:0]  dead_d   [NUM_MOTORS];
   logic [BLANK_W-1:0] blank_q  [NUM_MOTORS];
   logic [BLANK_W-1:0] blank_d  [NUM_MOTORS];
   logic [NUM_MOTORS-1:0] a_q, a_d, b_q, b_d, c_q, c_d, rdy_q, rdy_d;

   state_t             target   [NUM_MOTORS];
   logic [1:0]         ctrl     [NUM_MOTORS];
   logic [NUM_MOTORS-1:0] pwm_on;

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      sync_d = (cnt_q == '0);
      a_d    = '0;
      b_d    = '0;
      c_d    = '0;
      rdy_d  = '0;
      pwm_on = '0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
         // Shadow swaps on the last count so the new duty governs a whole period.
         shadow_d[i] = (cnt_q == '1) ? bus.Duty[i*PWM_W +: PWM_W] : shadow_q[i];
         pwm_on[i]   = (cnt_q < shadow_q[i]);
         ctrl[i]     = bus.Control[2*i +: 2];

         target[i] = ST_COAST;
         if (bus.Measure[i] || !bus.Enable || ctrl[i] == 2'b00)
            target[i] = ST_COAST;
         else if (!pwm_on[i] || ctrl[i] == 2'b11)
            target[i] = ST_BRAKE;
         else if (ctrl[i] == 2'b01)
            target[i] = ST_FWD;
         else
            target[i] = ST_REV;

         state_d[i] = state_q[i];
         dead_d[i]  = dead_q[i];
         if (state_q[i] == ST_DEAD) begin
            // Exit picks up whatever target is current now, not the one that caused entry.
            if (dead_q[i] <= 1) begin
               state_d[i] = target[i];
               dead_d[i]  = '0;
            end else begin
               dead_d[i]  = dead_q[i] - 1'b1;
            end
         end else if (target[i] != state_q[i]) begin
            if (bus.DeadTime == '0) begin
               state_d[i] = target[i];
            end else begin
               state_d[i] = ST_DEAD;
               dead_d[i]  = bus.DeadTime;
            end
         end

         // Pins are registered from the next state so they change with the state flop.
         a_d[i] = (state_d[i] == ST_FWD);
         b_d[i] = (state_d[i] == ST_REV);
         c_d[i] = (state_d[i] == ST_COAST);

         if (state_q[i] == ST_COAST && bus.Measure[i])
            blank_d[i] = (blank_q[i] == BLANK_MAX) ? blank_q[i] : blank_q[i] + 1'b1;
         else
            blank_d[i] = '0;
         rdy_d[i] = (blank_d[i] >= BLANK_MAX);
      end
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         cnt_q  <= '0;
         sync_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '1;
         rdy_q  <= '0;
         for (int i = 0; i < NUM_MOTORS; i++) begin
            shadow_q[i] <= '0;
            state_q[i]  <= ST_COAST;
            dead_q[i]   <= '0;
            blank_q[i]  <= '0;
         end
      end else begin
         cnt_q  <= cnt_d;
         sync_q <= sync_d;
         a_q    <= a_d;
         b_q    <= b_d;
         c_q    <= c_d;
         rdy_q  <= rdy_d;
         for (int i = 0; i < NUM_MOTORS; i++) begin
            shadow_q[i] <= shadow_d[i];
            state_q[i]  <= state_d[i];
            dead_q[i]   <= dead_d[i];
            blank_q[i]  <= blank_d[i];
         end
      end
   end

   assign bus.MotorA       = a_q;
   assign bus.MotorB       = b_q;
   assign bus.MotorC       = c_q;
   assign bus.MeasureReady = rdy_q;
   assign bus.PwmSync      = sync_q;
endmodule
